// File: rtl/decodifica_corriente.sv
// Serial BCD keypad entry decoder for the current setpoint: echoes up to four digits and
// converts a confirmed entry to a 5-bit code (mA/50). Macro REDONDEO_EN: round down instead of rejecting.
module decodifica_corriente #(
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digito,
    input  logic       digito_valido,
    input  logic       borrar,
    input  logic       confirmar,
    output logic [4:0] Corriente,
    output logic       corriente_valida,
    output logic       error,
    output logic [3:0] Un,
    output logic [3:0] De,
    output logic [3:0] Ce,
    output logic [3:0] Mi,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        ESPERA    = 3'd0,
        CAPTURA   = 3'd1,
        VALIDA    = 3'd2,
        RESULTADO = 3'd3,
        FALLO     = 3'd4
    } estado_t;

    localparam logic [3:0] BLANCO = 4'b1010;
    localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    // The count is compared one short of TIMEOUT_CICLOS-1 so the entry is abandoned on the
    // same edge the counter would reach that value.
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 2);

    estado_t       st;
    logic [CW-1:0] cnt;
    logic [3:0]    mi_v, ce_v, de_v, un_v;
    logic [13:0]   valor;
    logic [7:0]    codigo_ancho;
    logic          aprueba;
    logic          es_digito;

    assign estado    = st;
    assign es_digito = digito_valido && (digito < 4'd10);

    always_comb begin
        mi_v  = (Mi == BLANCO) ? 4'd0 : Mi;
        ce_v  = (Ce == BLANCO) ? 4'd0 : Ce;
        de_v  = (De == BLANCO) ? 4'd0 : De;
        un_v  = (Un == BLANCO) ? 4'd0 : Un;
        valor = 14'(mi_v) * 14'd1000 + 14'(ce_v) * 14'd100 + 14'(de_v) * 14'd10 + 14'(un_v);
`ifdef REDONDEO_EN
        codigo_ancho = 8'(mi_v) * 8'd20 + 8'(ce_v) * 8'd2 + {7'd0, (de_v >= 4'd5)};
        aprueba      = (valor <= 14'd1000);
`else
        codigo_ancho = 8'(mi_v) * 8'd20 + 8'(ce_v) * 8'd2 + {7'd0, (de_v == 4'd5)};
        aprueba      = (un_v == 4'd0) && ((de_v == 4'd0) || (de_v == 4'd5)) && (valor <= 14'd1000);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st               <= ESPERA;
            cnt              <= '0;
            Corriente        <= 5'd0;
            corriente_valida <= 1'b0;
            error            <= 1'b0;
            Un               <= BLANCO;
            De               <= BLANCO;
            Ce               <= BLANCO;
            Mi               <= BLANCO;
        end else begin
            corriente_valida <= 1'b0;
            cnt              <= '0;
            case (st)
                VALIDA: begin
                    if (aprueba) begin
                        Corriente        <= codigo_ancho[4:0];
                        corriente_valida <= 1'b1;
                        Un               <= BLANCO;
                        De               <= BLANCO;
                        Ce               <= BLANCO;
                        Mi               <= BLANCO;
                        st               <= RESULTADO;
                    end else begin
                        error <= 1'b1;
                        st    <= FALLO;
                    end
                end
                RESULTADO: st <= ESPERA;
                default: begin
                    if (borrar) begin
                        error <= 1'b0;
                        Un    <= BLANCO;
                        De    <= BLANCO;
                        Ce    <= BLANCO;
                        Mi    <= BLANCO;
                        st    <= ESPERA;
                    end else if (st == ESPERA) begin
                        if (es_digito) begin
                            Un <= digito;
                            st <= CAPTURA;
                        end
                    end else if (st == CAPTURA) begin
                        // An accepted digit beats the timeout on the same edge.
                        if (confirmar) begin
                            st <= VALIDA;
                        end else if (es_digito && (Mi == BLANCO)) begin
                            Mi <= Ce;
                            Ce <= De;
                            De <= Un;
                            Un <= digito;
                        end else if (cnt == LIMITE) begin
                            Un <= BLANCO;
                            De <= BLANCO;
                            Ce <= BLANCO;
                            Mi <= BLANCO;
                            st <= ESPERA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (st == FALLO) begin
                        if (es_digito) begin
                            error <= 1'b0;
                            Mi    <= BLANCO;
                            Ce    <= BLANCO;
                            De    <= BLANCO;
                            Un    <= digito;
                            st    <= CAPTURA;
                        end
                    end else begin
                        st <= ESPERA;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decodifica_corriente.sv
// Bench for decodifica_corriente: directed keypad sequences, scoreboard of expected
// {error, Corriente} results popped by a monitor on each valid pulse or error rise.
module tb_decodifica_corriente;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digito;
    logic       digito_valido;
    logic       borrar;
    logic       confirmar;
    logic [4:0] Corriente;
    logic       corriente_valida;
    logic       error;
    logic [3:0] Un, De, Ce, Mi;
    logic [2:0] estado;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];
    logic       error_prev = 1'b0;

    decodifica_corriente #(.TIMEOUT_CICLOS(16)) dut (
        .clk(clk),
        .reset(reset),
        .digito(digito),
        .digito_valido(digito_valido),
        .borrar(borrar),
        .confirmar(confirmar),
        .Corriente(Corriente),
        .corriente_valida(corriente_valida),
        .error(error),
        .Un(Un),
        .De(De),
        .Ce(Ce),
        .Mi(Mi),
        .estado(estado)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tic();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digito        = d;
        digito_valido = 1'b1;
        tic();
        digito_valido = 1'b0;
    endtask

    task automatic confirm();
        confirmar = 1'b1;
        tic();
        confirmar = 1'b0;
    endtask

    task automatic clear();
        borrar = 1'b1;
        tic();
        borrar = 1'b0;
    endtask

    // Monitor: one expected entry per valid pulse or rising error.
    always @(negedge clk) begin
        if (!reset && (corriente_valida || (error && !error_prev))) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got err=%0b code=%0d, expected nothing", error, Corriente);
            end else begin
                chk("scoreboard", {26'd0, error, Corriente}, {26'd0, exp_q.pop_front()});
            end
        end
        error_prev = error;
    end

    initial begin
        reset = 1'b1; digito = 4'd0; digito_valido = 1'b0; borrar = 1'b0; confirmar = 1'b0;
        tic(); tic();
        reset = 1'b0;
        chk("rst_corriente", Corriente, 0);
        chk("rst_valida", corriente_valida, 0);
        chk("rst_error", error, 0);
        chk("rst_echo", {Mi, Ce, De, Un}, 16'hAAAA);
        chk("rst_estado", estado, 0);

        // 650 mA -> 13, checked at exact latency
        key(6); key(5); key(0);
        chk("echo_650", {Mi, Ce, De, Un}, 16'hA650);
        exp_q.push_back({1'b0, 5'd13});
        confirm();
        chk("valida_n1", corriente_valida, 0);
        tic();
        chk("valida_n2", corriente_valida, 1);
        chk("corriente_13", Corriente, 13);
        chk("echo_blank_ok", {Mi, Ce, De, Un}, 16'hAAAA);
        tic();
        chk("pulse_single", corriente_valida, 0);

        // 1000 -> 20, then 1050 rejected
        key(1); key(0); key(0); key(0);
        exp_q.push_back({1'b0, 5'd20});
        confirm(); tic(); tic();
        chk("corriente_20", Corriente, 20);
        key(1); key(0); key(5); key(0);
        exp_q.push_back({1'b1, 5'd20});
        confirm(); tic();
        chk("error_1050", error, 1);
        chk("corriente_hold", Corriente, 20);
        chk("echo_1050", {Mi, Ce, De, Un}, 16'h1050);
        key(5);
        chk("error_cleared", error, 0);
        chk("echo_restart", {Mi, Ce, De, Un}, 16'hAAA5);
        clear();

        // borrar beats a same-cycle digit; confirm in ESPERA does nothing
        key(1); key(2); key(3);
        digito = 4'd4; digito_valido = 1'b1; borrar = 1'b1;
        tic();
        digito_valido = 1'b0; borrar = 1'b0;
        chk("echo_borrar", {Mi, Ce, De, Un}, 16'hAAAA);
        chk("estado_borrar", estado, 0);
        chk("error_borrar", error, 0);
        confirm(); tic(); tic();
        chk("espera_confirm_v", corriente_valida, 0);
        chk("espera_confirm_e", error, 0);

        // fifth digit dropped; leading zeros kept
        key(0); key(0); key(5); key(0); key(7);
        chk("echo_0050", {Mi, Ce, De, Un}, 16'h0050);
        exp_q.push_back({1'b0, 5'd1});
        confirm(); tic(); tic();
        chk("corriente_1", Corriente, 1);

        // confirmar beats a same-cycle digit
        key(1); key(5);
        digito = 4'd0; digito_valido = 1'b1;
        tic();
        digito = 4'd7; confirmar = 1'b1;
        exp_q.push_back({1'b0, 5'd3});
        tic();
        digito_valido = 1'b0; confirmar = 1'b0;
        tic(); tic();
        chk("corriente_3", Corriente, 3);

        // timeout: 15 idle cycles abandon the entry
        key(3);
        repeat (14) tic();
        chk("echo_pre_timeout", {Mi, Ce, De, Un}, 16'hAAA3);
        tic();
        chk("echo_timeout", {Mi, Ce, De, Un}, 16'hAAAA);
        chk("estado_timeout", estado, 0);
        chk("error_timeout", error, 0);
        chk("corriente_timeout", Corriente, 3);

        // a digit on the last idle cycle keeps the entry and restarts the count
        key(3);
        repeat (14) tic();
        key(0);
        chk("echo_kept", {Mi, Ce, De, Un}, 16'hAA30);
        repeat (14) tic();
        chk("echo_kept2", {Mi, Ce, De, Un}, 16'hAA30);
        tic();
        chk("echo_timeout2", {Mi, Ce, De, Un}, 16'hAAAA);

        // 749: rejected in strict mode, rounds to 700 otherwise
        key(7); key(4); key(9);
`ifdef REDONDEO_EN
        exp_q.push_back({1'b0, 5'd14});
        confirm(); tic();
        chk("corriente_749", Corriente, 14);
        chk("valida_749", corriente_valida, 1);
`else
        exp_q.push_back({1'b1, 5'd3});
        confirm(); tic();
        chk("error_749", error, 1);
        chk("corriente_749", Corriente, 3);
`endif
        tic();
        clear();

        // reset during VALIDA suppresses the result
        key(1); key(0); key(0);
        confirm();
        reset = 1'b1;
        tic();
        reset = 1'b0;
        chk("rst_valida_v", corriente_valida, 0);
        chk("rst_valida_c", Corriente, 0);
        chk("rst_valida_echo", {Mi, Ce, De, Un}, 16'hAAAA);
        chk("rst_valida_st", estado, 0);
        tic(); tic(); tic();
        chk("rst_no_pulse", corriente_valida, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decodifica_corriente.md
Name: decodifica_corriente

Overview:
- Serial BCD entry decoder for the current setpoint. It is the inverse of the current-to-BCD display encoder.
- Operator keys decimal digits one at a time (mA, multiples of 50, 0..1000). The block echoes them as four BCD display digits and, on confirm, validates the entry.
- On success it emits the 5-bit current code (value/50, 0..20) with a one-cycle valid strobe.
- Sits between the keypad scanner and the current-control register.

Parameters:
- TIMEOUT_CICLOS, 50000000, idle cycles after last accepted digit before the entry is abandoned (1 s at 50 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- digito  input  4  BCD digit from keypad; 10..15 are non-digit keys and are ignored
- digito_valido  input  1  one-cycle strobe qualifying digito
- borrar  input  1  one-cycle strobe, clear entry
- confirmar  input  1  one-cycle strobe, evaluate entry
- Corriente  output  5  decoded current code, registered, holds last successful value
- corriente_valida  output  1  one-cycle pulse when Corriente is updated
- error  output  1  level, entry rejected
- Un  output  4  echo units digit; 4'b1010 = blank
- De  output  4  echo tens digit; 4'b1010 = blank
- Ce  output  4  echo hundreds digit; 4'b1010 = blank
- Mi  output  4  echo thousands digit; 4'b1010 = blank

Behaviour:
- Reset, synchronous, active-high:
  - Corriente=0, corriente_valida=0, error=0.
  - Un/De/Ce/Mi=4'b1010; state=ESPERA; timeout counter=0.
- Same-cycle priority: reset > borrar > confirmar > digito_valido.
- FSM states:
  - ESPERA: entry empty. A digit (0..9) loads Un=digito and goes to CAPTURA. confirmar is ignored.
  - CAPTURA: a digit (0..9) shifts left: Mi<=Ce, Ce<=De, De<=Un, Un<=digito. The shift is accepted only while Mi is blank; a 5th digit is silently dropped. confirmar goes to VALIDA.
  - VALIDA: one cycle. Compute V = Mi*1000+Ce*100+De*10+Un, with blank treated as 0. Register the check result. Next state is RESULTADO on pass, FALLO on fail.
  - RESULTADO: one cycle. Load Corriente = Mi*20 + Ce*2 + (De==5). Pulse corriente_valida. Clear echo to all blank. Go to ESPERA.
  - FALLO:
    - error=1, echo keeps the rejected entry.
    - borrar: echo blank, error=0, go to ESPERA.
    - Digit 0..9: error=0, echo blanked and Un=digito in the same cycle, go to CAPTURA.
    - confirmar is ignored.
- Pass condition: Un==0, De is 0 or 5, V<=1000.
- Latency: confirmar sampled in cycle N; corriente_valida or error high in cycle N+2.
- All keypad strobes are ignored while in VALIDA or RESULTADO.
- borrar in any state except during reset: echo blank, error=0, go to ESPERA, Corriente unchanged.
- Leading zeros are kept as keyed ("0050" is legal and decodes to 1).
- Timeout, CAPTURA only:
  - The counter clears on every accepted digit.
  - When it reaches TIMEOUT_CICLOS-1: echo blank, go to ESPERA, no error, Corriente unchanged.
  - The counter is held at 0 in all other states.
- Corriente never changes except in RESULTADO; a failed entry leaves it at its previous value.
- Mi is 0 or 1 for any passing entry. Mi>=2 or V>1000 fails.

Optional Feature:
- Macro: REDONDEO_EN.
- Defined:
  - Non-multiple entries round down instead of failing.
  - Pass condition becomes V<=1000 only.
  - Un is ignored; code = Mi*20 + Ce*2 + (De>=5). Example: 749 -> 14 (700).
- Undefined: strict check as above; 749 -> error.

Test Plan:
- Reset, then keys 6,5,0, then confirmar -> echo Mi=A Ce=6 De=5 Un=0 before confirm; 2 cycles after confirm, Corriente=13 and a single corriente_valida pulse; echo all 4'b1010.
- Keys 1,0,0,0, confirm -> Corriente=20. Then keys 1,0,5,0, confirm -> error=1, Corriente stays 20, echo shows 1050. Then key 5 -> error=0, echo Un=5 only.
- Keys 1,2,3 then borrar in the same cycle as digit 4 -> echo all blank, state ESPERA, no error. Confirm in ESPERA -> no pulse, no error.
- Keys 0,0,5,0,7 -> the 7 is dropped; confirm -> Corriente=1. Key 7 with confirmar in the same cycle -> 7 ignored, decode of prior entry.
- TIMEOUT_CICLOS=16: key 3, idle 15 cycles -> echo blank; idle 14 cycles then key 0 -> entry kept, counter restarts.
- Keys 7,4,9, confirm -> error=1 without REDONDEO_EN; Corriente=14 and valid pulse with REDONDEO_EN. Reset asserted during VALIDA -> outputs at reset values next cycle, no pulse.
